pkt_mem_arbiter: RTL and testbench
==================================

Name: pkt_mem_arbiter

Overview:
- Shares the single packet-memory port between several masters: parser, deparser/action engine and packet DMA writer.
- Each master drives its own copy of the ce/we/addr/width/data bundle, the same bundle the parser already drives.
- The arbiter grants exactly one master at a time, using round-robin with a bounded hold time.
- The granted master's bundle is muxed onto the memory port, and read data is broadcast back to all masters.

Parameters:
NUM_REQ, 3, number of requesting masters (index 0 = parser)
ADDR_WIDTH, 32, width of `ADDR_BUS
DATA_WIDTH, 32, width of `DATA_BUS
MAX_HOLD, 16, max consecutive granted cycles while another master waits; 0 = unlimited

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_ce_i  in  NUM_REQ  per-master request / chip enable
req_we_i  in  NUM_REQ  per-master write enable
req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-master address, master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_width_i  in  NUM_REQ*4  per-master access width in bytes
req_data_i  in  NUM_REQ*DATA_WIDTH  per-master write data
gnt_o  out  NUM_REQ  one-hot grant (registered)
rdata_o  out  DATA_WIDTH  memory read data, broadcast
busy_o  out  1  any grant active
owner_o  out  clog2(NUM_REQ)  index of current owner; 0 when idle
mem_ce_o  out  1  to memory
mem_we_o  out  1  to memory
mem_addr_o  out  ADDR_WIDTH  to memory
mem_width_o  out  4  to memory
mem_data_o  out  DATA_WIDTH  to memory
mem_data_i  in  DATA_WIDTH  from memory

Behaviour:
- Reset (rst high at posedge):
  - state=ARB_IDLE, gnt_o=0, owner=0, rr_ptr=0, hold_cnt=0.
  - Because the mem outputs are derived from the grant register, they read 0 from the cycle after reset.
  - Reset mid-transfer drops the grant immediately; no completion.
- Registered state: state, one-hot grant, owner index, rr_ptr, hold_cnt. Everything else is combinational.
- Memory mux (combinational):
  - When busy_o=1: mem_ce_o = req_ce_i[owner] and mem_we_o = req_we_i[owner] & req_ce_i[owner]. addr/width/data are taken from the owner's slice.
  - When idle: all mem outputs are 0.
  - rdata_o = mem_data_i always; only the owner may consume it.
- Requester rule:
  - A master asserts ce and holds ce, addr, width and data stable until it sees gnt_o[i]=1.
  - The first access counts on the first cycle gnt_o[i]=1.
  - A master keeps ce high across a multi-access sequence to retain ownership (e.g. parser tag reads).
  - Deasserting ce releases ownership.
- Grant latency: a request arriving at an idle arbiter at cycle t gets gnt_o high at t+1.
- Selection: scan masters starting at rr_ptr, wrapping modulo NUM_REQ; the first with ce=1 wins. On every new grant, rr_ptr <= winner+1 (mod NUM_REQ).
- ARB_IDLE:
  - Any ce high -> select, load grant and owner, hold_cnt=0, go to ARB_GRANT.
  - No ce high -> stay.
- ARB_GRANT, evaluated each cycle:
  - Release: req_ce_i[owner]=0.
    - Reselect among the other masters in the same cycle, so the new grant is visible next cycle with no idle bubble.
    - If none are requesting -> ARB_IDLE, gnt_o=0 next cycle.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another master's ce is high.
    - Force reselection, excluding the owner, starting at owner+1.
    - The preempted master loses gnt next cycle. It keeps ce high and re-queues, then wins again by round-robin.
  - Otherwise: hold the grant. hold_cnt increments, saturating at MAX_HOLD-1.
  - hold_cnt resets to 0 on every new grant.
  - Owner alone with no contender never gets preempted.
- Simultaneous events:
  - Owner release in the same cycle as a preempt condition is handled as a release.
  - A master dropping ce in the very cycle it is granted is treated as a release on that cycle.
- Width rule: owner_o width is max(1, clog2(NUM_REQ)). hold_cnt width is max(1, clog2(MAX_HOLD)).

Test Plan:
- Reset/idle: rst=1 for 2 cycles with ce=3'b111 -> gnt_o=0 and mem_ce_o=0 during reset. First grant goes to master 0 at the cycle after rst falls + 1.
- Single master: master 0 ce=1, addr=0x100C, width=4 for 3 cycles.
  - gnt_o=3'b001 from cycle 2.
  - mem_addr_o=0x100C while granted.
  - rdata_o tracks mem_data_i.
  - ce drop -> gnt_o=0 the next cycle.
- Round-robin: all three masters hold ce, each dropping it after 2 granted cycles -> grant order 0,1,2,0. Handoffs are back-to-back with no cycle where busy_o=0.
- Preemption (MAX_HOLD=4): master 1 holds ce indefinitely; master 2 requests at cycle 1.
  - Master 1 keeps gnt for 4 cycles, then gnt moves to master 2.
  - Master 1 regains gnt after master 2 releases.
- Write pass-through: master 2 we=1, addr=0x2000, data=0xDEADBEEF -> mem_we_o=1 with exact addr/data only while gnt_o[2]=1. Non-owner we=1 never reaches mem_we_o.
- Reset mid-grant: rst pulse while master 0 is owner -> gnt_o=0, mem_ce_o=0 next cycle. After reset, the pending master 1 is granted first only if master 0 has dropped ce (rr_ptr back at 0).

Source files
------------

// File: rtl/pkt_mem_arbiter.sv
// Round-robin arbiter sharing one packet-memory port between several masters.
// Grants are registered; the owner's bundle is muxed to memory combinationally.
module pkt_mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_ce_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*4-1:0]             req_width_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             busy_o,
  output logic [OW-1:0]                    owner_o,
  output logic                             mem_ce_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [3:0]                       mem_width_o,
  output logic [DATA_WIDTH-1:0]            mem_data_o,
  input  logic [DATA_WIDTH-1:0]            mem_data_i
);

  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [OW-1:0]       owner_reg, owner_next;
  logic [OW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;

  logic [NUM_REQ-1:0]  cand;
  logic [OW-1:0]       scan_start;
  logic [OW-1:0]       win;
  logic                win_valid;
  logic [OW-1:0]       win_plus1;
  logic [OW-1:0]       owner_plus1;
  logic                owner_ce;
  logic                hold_limit;
  logic                do_select;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [3:0]            width_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign width_arr[gi] = req_width_i[gi*4 +: 4];
    assign data_arr[gi]  = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owner_ce    = |(req_ce_i & gnt_reg);
  assign hold_limit  = (MAX_HOLD != 0) && (hold_cnt_reg == HW'(MAX_HOLD - 1));
  assign owner_plus1 = (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
  assign win_plus1   = (win == OW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // While granted the owner is never a candidate, so a reselect always moves on.
  always_comb begin
    cand       = req_ce_i;
    scan_start = rr_ptr_reg;
    if (state_reg == ARB_GRANT) begin
      cand       = req_ce_i & ~gnt_reg;
      scan_start = owner_ce ? owner_plus1 : rr_ptr_reg;
    end
  end

  // Winner is the candidate with the smallest rotational distance from scan_start.
  always_comb begin
    int best_d;
    int d;
    win       = '0;
    win_valid = 1'b0;
    best_d    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(scan_start)) % NUM_REQ;
      if (cand[i] && (d < best_d)) begin
        best_d    = d;
        win       = OW'(i);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    do_select     = 1'b0;
    case (state_reg)
      ARB_IDLE: do_select = |req_ce_i;
      ARB_GRANT: begin
        if (!owner_ce) begin
          do_select = 1'b1;
        end else if (hold_limit && (|cand)) begin
          do_select = 1'b1;
        end else if ((MAX_HOLD != 0) && !hold_limit) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
    if (do_select) begin
      hold_cnt_next = '0;
      if (win_valid) begin
        state_next  = ARB_GRANT;
        gnt_next    = NUM_REQ'(1) << win;
        owner_next  = win;
        rr_ptr_next = win_plus1;
      end else begin
        state_next = ARB_IDLE;
        gnt_next   = '0;
        owner_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      gnt_reg      <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // The one-hot grant selects the owner's bundle; all-zero grant yields zeros.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) begin
        mem_ce_o    = req_ce_i[i];
        mem_we_o    = req_we_i[i] & req_ce_i[i];
        mem_addr_o  = addr_arr[i];
        mem_width_o = width_arr[i];
        mem_data_o  = data_arr[i];
      end
    end
  end

  assign gnt_o   = gnt_reg;
  assign busy_o  = |gnt_reg;
  assign owner_o = owner_reg;
  assign rdata_o = mem_data_i;

endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// Directed bench for pkt_mem_arbiter: reset, single master, round-robin,
// preemption, write pass-through and reset during a grant.
module tb_pkt_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ce, we;
  logic [95:0] addr, data;
  logic [11:0] width;
  logic [31:0] mem_data;
  logic [2:0]  gnt_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic [1:0]  owner_o;
  logic        mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_width_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_mem_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(ce), .req_we_i(we), .req_addr_i(addr), .req_width_i(width), .req_data_i(data),
    .gnt_o(gnt_o), .rdata_o(rdata_o), .busy_o(busy_o), .owner_o(owner_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = '0; we = '0; addr = '0; data = '0; width = '0; mem_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 3'b111; we = '0; addr = '0; data = '0; width = '0; mem_data = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt_o !== 3'b000 || mem_ce_o !== 1'b0 || busy_o !== 1'b0 || owner_o !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold c%0d: gnt=%b mem_ce=%b busy=%b owner=%0d want gnt=000 mem_ce=0 busy=0 owner=0",
                 c, gnt_o, mem_ce_o, busy_o, owner_o);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt_o !== 3'b001 || owner_o !== 2'd0 || mem_ce_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b owner=%0d mem_ce=%b want 001/0/1", gnt_o, owner_o, mem_ce_o);
    end
    $display("test_reset: first grant gnt=%b", gnt_o);
    ce = 3'b000;
    tick();
    checks++;
    if (gnt_o !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: gnt=%b want 000", gnt_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    ce = 3'b001; addr[31:0] = 32'h0000_100C; width[3:0] = 4'd4;
    for (int c = 0; c < 3; c++) begin
      mem_data = 32'hA5A5_0000 + c;
      tick();
      checks++;
      if (gnt_o !== 3'b001 || mem_addr_o !== 32'h0000_100C || mem_width_o !== 4'd4 ||
          mem_ce_o !== 1'b1 || mem_we_o !== 1'b0 || rdata_o !== (32'hA5A5_0000 + c)) begin
        errors++;
        $display("FAIL single c%0d: gnt=%b addr=%h width=%0d ce=%b we=%b rdata=%h want 001/0000100c/4/1/0/%h",
                 c, gnt_o, mem_addr_o, mem_width_o, mem_ce_o, mem_we_o, rdata_o, 32'hA5A5_0000 + c);
      end
      $display("test_single: cycle %0d gnt=%b addr=%h rdata=%h", c, gnt_o, mem_addr_o, rdata_o);
    end
    ce = 3'b000;
    tick();
    checks++;
    if (gnt_o !== 3'b000 || mem_addr_o !== 32'h0 || mem_ce_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_release: gnt=%b addr=%h ce=%b busy=%b want 000/0/0/0", gnt_o, mem_addr_o, mem_ce_o, busy_o);
    end
  endtask

  task automatic check_table(input string name, input logic [2:0] ce_tab [8],
                             input logic [2:0] gnt_tab [8], input logic [1:0] own_tab [8]);
    for (int s = 0; s < 8; s++) begin
      ce = ce_tab[s];
      tick();
      checks++;
      if (gnt_o !== gnt_tab[s] || owner_o !== own_tab[s] || busy_o !== (gnt_tab[s] != 3'b000)) begin
        errors++;
        $display("FAIL %s step %0d: gnt=%b owner=%0d busy=%b want gnt=%b owner=%0d busy=%b",
                 name, s, gnt_o, owner_o, busy_o, gnt_tab[s], own_tab[s], gnt_tab[s] != 3'b000);
      end
      $display("%s: step %0d ce=%b gnt=%b owner=%0d", name, s, ce_tab[s], gnt_o, owner_o);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] ce_tab  [8] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b101, 3'b001, 3'b000};
    logic [2:0] gnt_tab [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b000};
    logic [1:0] own_tab [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    do_reset();
    check_table("rr", ce_tab, gnt_tab, own_tab);
  endtask

  task automatic test_preempt();
    logic [2:0] ce_tab  [8] = '{3'b010, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b010, 3'b000};
    logic [2:0] gnt_tab [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b010, 3'b000};
    logic [1:0] own_tab [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    do_reset();
    check_table("preempt", ce_tab, gnt_tab, own_tab);
  endtask

  task automatic test_write();
    do_reset();
    ce = 3'b100; we = 3'b110;
    addr[64 +: 32] = 32'h0000_2000; data[64 +: 32] = 32'hDEAD_BEEF; width[8 +: 4] = 4'd4;
    addr[32 +: 32] = 32'h0000_3000; data[32 +: 32] = 32'h1234_5678; width[4 +: 4] = 4'd2;
    #1;
    checks++;
    if (mem_we_o !== 1'b0 || mem_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: mem_we=%b mem_ce=%b want 0/0", mem_we_o, mem_ce_o);
    end
    tick();
    checks++;
    if (gnt_o !== 3'b100 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_2000 || mem_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_owner2: gnt=%b we=%b addr=%h data=%h want 100/1/00002000/deadbeef",
               gnt_o, mem_we_o, mem_addr_o, mem_data_o);
    end
    $display("test_write: gnt=%b we=%b addr=%h data=%h", gnt_o, mem_we_o, mem_addr_o, mem_data_o);
    ce = 3'b110;
    tick();
    checks++;
    if (gnt_o !== 3'b100 || mem_addr_o !== 32'h0000_2000 || mem_data_o !== 32'hDEAD_BEEF || mem_width_o !== 4'd4) begin
      errors++;
      $display("FAIL write_nonowner: gnt=%b addr=%h data=%h width=%0d want 100/00002000/deadbeef/4",
               gnt_o, mem_addr_o, mem_data_o, mem_width_o);
    end
    ce = 3'b010;
    #1;
    checks++;
    if (mem_we_o !== 1'b0 || mem_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL write_ce_mask: mem_we=%b mem_ce=%b want 0/0", mem_we_o, mem_ce_o);
    end
    tick();
    checks++;
    if (gnt_o !== 3'b010 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_3000 || mem_data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_handoff: gnt=%b we=%b addr=%h data=%h want 010/1/00003000/12345678",
               gnt_o, mem_we_o, mem_addr_o, mem_data_o);
    end
    $display("test_write: handoff gnt=%b addr=%h", gnt_o, mem_addr_o);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ce = 3'b001;
    tick();
    ce = 3'b011;
    tick();
    checks++;
    if (gnt_o !== 3'b001) begin
      errors++;
      $display("FAIL mid_owner: gnt=%b want 001", gnt_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt_o !== 3'b000 || mem_ce_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b mem_ce=%b busy=%b want 000/0/0", gnt_o, mem_ce_o, busy_o);
    end
    rst = 1'b0; ce = 3'b010;
    tick();
    checks++;
    if (gnt_o !== 3'b010 || owner_o !== 2'd1) begin
      errors++;
      $display("FAIL mid_after_drop: gnt=%b owner=%0d want 010/1", gnt_o, owner_o);
    end
    $display("test_reset_mid: after reset with m0 dropped gnt=%b", gnt_o);
    rst = 1'b1; ce = 3'b011;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (gnt_o !== 3'b001 || owner_o !== 2'd0) begin
      errors++;
      $display("FAIL mid_after_hold: gnt=%b owner=%0d want 001/0", gnt_o, owner_o);
    end
    $display("test_reset_mid: after reset with m0 held gnt=%b", gnt_o);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
